// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: LC-3 memory/IO access controller with programmable SRAM wait states and hex display register.
// Define MEM_IO_ACCESS_CNT_EN to add an access counter readable/clearable at IO_ADDR-1.
module mem_io_ctrl #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int SW_W = 16,
    parameter int HEX_DIGITS = 4,
    parameter int WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR = 'hFFFF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Req,
    input  logic                    Rd_Wr,
    input  logic [ADDR_W-1:0]       A,
    input  logic [DATA_W-1:0]       Data_from_CPU,
    output logic [DATA_W-1:0]       Data_to_CPU,
    output logic                    Ready,
    output logic                    Busy,
    input  logic [SW_W-1:0]         Switches,
    output logic [4*HEX_DIGITS-1:0] HEX_Out,
    output logic [ADDR_W-1:0]       Mem_A,
    output logic [DATA_W-1:0]       Mem_Dout,
    input  logic [DATA_W-1:0]       Mem_Din,
    output logic                    Mem_CE,
    output logic                    Mem_OE,
    output logic                    Mem_WE,
    output logic                    Mem_UB,
    output logic                    Mem_LB
);
    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
    state_t state;
    logic rd;
    logic [3:0] wait_cnt;
    logic io_hit, cnt_hit;
    logic [DATA_W-1:0] io_rdata;
    assign io_hit = A == IO_ADDR;
`ifdef MEM_IO_ACCESS_CNT_EN
    localparam logic [ADDR_W-1:0] CNT_ADDR = IO_ADDR - 1'b1;
    logic [DATA_W-1:0] acc_cnt;
    logic skip_cnt;
    assign cnt_hit = A == CNT_ADDR;
    assign io_rdata = io_hit ? DATA_W'(Switches) : acc_cnt;
    // The clearing write arms skip_cnt so its own Ready pulse is not counted
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            acc_cnt <= '0;
            skip_cnt <= 1'b0;
        end else if (state == IDLE && Req && cnt_hit && !Rd_Wr) begin
            acc_cnt <= '0;
            skip_cnt <= 1'b1;
        end else if (Ready) begin
            acc_cnt <= skip_cnt ? acc_cnt : acc_cnt + 1'b1;
            skip_cnt <= 1'b0;
        end
`else
    assign cnt_hit = 1'b0;
    assign io_rdata = DATA_W'(Switches);
`endif
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            state <= IDLE;
            rd <= 1'b0;
            wait_cnt <= '0;
            Ready <= 1'b0;
            Busy <= 1'b0;
            Data_to_CPU <= '0;
            HEX_Out <= '0;
            Mem_A <= '0;
            Mem_Dout <= '0;
            {Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB} <= '1;
        end else
            case (state)
                IDLE:
                    if (Req) begin
                        rd <= Rd_Wr;
                        Busy <= 1'b1;
                        if (io_hit || cnt_hit) begin
                            if (Rd_Wr) Data_to_CPU <= io_rdata;
                            else if (io_hit) HEX_Out <= Data_from_CPU[4*HEX_DIGITS-1:0];
                            Ready <= 1'b1;
                            state <= DONE;
                        end else begin
                            Mem_A <= A;
                            if (!Rd_Wr) Mem_Dout <= Data_from_CPU;
                            {Mem_CE, Mem_UB, Mem_LB} <= '0;
                            Mem_OE <= !Rd_Wr;
                            Mem_WE <= Rd_Wr;
                            wait_cnt <= 4'(WAIT_STATES);
                            state <= MEM;
                        end
                    end
                MEM:
                    if (wait_cnt == 4'd0) begin
                        if (rd) Data_to_CPU <= Mem_Din;
                        {Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB} <= '1;
                        Ready <= 1'b1;
                        state <= DONE;
                    end else
                        wait_cnt <= wait_cnt - 1'b1;
                default: begin
                    Ready <= 1'b0;
                    Busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: table-driven accesses with a scoreboard plus reset, back-to-back and ignored-Req sequences.
module tb_mem_io_ctrl;
    localparam int WS = 2;
    logic Clk = 1'b0, Reset = 1'b0, Req = 1'b0, Rd_Wr = 1'b0;
    logic [19:0] A = '0;
    logic [15:0] Data_from_CPU = '0, Switches = '0, Mem_Din = '0;
    logic [15:0] Data_to_CPU, HEX_Out, Mem_Dout;
    logic [19:0] Mem_A;
    logic Ready, Busy, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
    int n_cmp = 0, n_err = 0;

    mem_io_ctrl #(.WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Rd_Wr(Rd_Wr), .A(A),
        .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Ready(Ready), .Busy(Busy),
        .Switches(Switches), .HEX_Out(HEX_Out), .Mem_A(Mem_A), .Mem_Dout(Mem_Dout), .Mem_Din(Mem_Din),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd;
        logic [19:0] addr;
        logic [15:0] wd, sw, din, exp_data, exp_hex;
    } vec_t;
    vec_t vecs[7];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_io(input logic [19:0] a);
`ifdef MEM_IO_ACCESS_CNT_EN
        return a == 20'h0FFFF || a == 20'h0FFFE;
`else
        return a == 20'h0FFFF;
`endif
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t e;
        logic io;
        int lat, ce_n, oe_n, we_n;
        logic [19:0] ma;
        logic [15:0] md;
        ma = '0;
        md = '0;
        io = is_io(v.addr);
        @(negedge Clk);
        Req = 1'b1; Rd_Wr = v.rd; A = v.addr; Data_from_CPU = v.wd; Switches = v.sw; Mem_Din = v.din;
        sb.push_back(v);
        @(negedge Clk);
        Req = 1'b0;
        lat = 1; ce_n = 0; oe_n = 0; we_n = 0;
        forever begin
            if ({Mem_CE, Mem_UB, Mem_LB} == 3'b000) begin
                ce_n++;
                ma = Mem_A;
                md = Mem_Dout;
            end
            if (!Mem_OE) oe_n++;
            if (!Mem_WE) we_n++;
            if (Ready || lat >= 40) break;
            @(negedge Clk);
            lat++;
        end
        e = sb.pop_front();
        check("ready_seen", 32'(Ready), 32'd1);
        check("data", 32'(Data_to_CPU), 32'(e.exp_data));
        check("hex", 32'(HEX_Out), 32'(e.exp_hex));
        check("latency", 32'(lat), io ? 32'd1 : 32'(WS + 2));
        check("ce_cycles", 32'(ce_n), io ? 32'd0 : 32'(WS + 1));
        check("oe_cycles", 32'(oe_n), (!io && e.rd) ? 32'(WS + 1) : 32'd0);
        check("we_cycles", 32'(we_n), (!io && !e.rd) ? 32'(WS + 1) : 32'd0);
        if (!io) check("mem_a", 32'(ma), 32'(e.addr));
        if (!io && !e.rd) check("mem_dout", 32'(md), 32'(e.wd));
        @(negedge Clk);
        check("ready_drop_busy", 32'({Ready, Busy}), 32'd0);
    endtask

    initial begin
        int pulses, first, second;
        vecs[0] = '{1'b1, 20'h00010, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 20'h00020, 16'h1234, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 20'h0FFFF, 16'hCAFE, 16'h0000, 16'h0000, 16'hBEEF, 16'hCAFE};
        vecs[3] = '{1'b1, 20'h0FFFF, 16'h0000, 16'h00A5, 16'h0000, 16'h00A5, 16'hCAFE};
        vecs[4] = '{1'b1, 20'h1FFFF, 16'h0000, 16'h00FF, 16'h0001, 16'h0001, 16'hCAFE};
        vecs[5] = '{1'b0, 20'h0FFFD, 16'h5A5A, 16'h0000, 16'h0000, 16'h0001, 16'hCAFE};
        vecs[6] = '{1'b1, 20'h00000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hCAFE};

        repeat (2) @(negedge Clk);
        check("reset_ready_busy", 32'({Ready, Busy}), 32'd0);
        check("reset_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}), 32'h1F);
        check("reset_regs", 32'(|{Mem_A, Mem_Dout, Data_to_CPU, HEX_Out}), 32'd0);
        Reset = 1'b1;

        // reset during the second MEM cycle of a read
        @(negedge Clk);
        Req = 1'b1; Rd_Wr = 1'b1; A = 20'h00010; Mem_Din = 16'hBEEF;
        @(negedge Clk);
        Req = 1'b0;
        check("mid_strobes_active", 32'({Mem_CE, Mem_OE}), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("mid_reset_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}), 32'h1F);
        check("mid_reset_busy", 32'({Ready, Busy}), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (Ready) pulses++;
        end
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (Ready) pulses++;
        end
        check("mid_reset_no_ready", 32'(pulses), 32'd0);
        check("mid_reset_data", 32'(Data_to_CPU), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Req held high: one access every WS+3 cycles
        @(negedge Clk);
        Req = 1'b1; Rd_Wr = 1'b1; A = 20'h00010; Mem_Din = 16'hBEEF;
        pulses = 0; first = 0; second = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge Clk);
            if (Ready) begin
                pulses++;
                if (pulses == 1) first = i;
                if (pulses == 2) second = i;
            end
        end
        Req = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd3);
        check("b2b_first", 32'(first), 32'(WS + 2));
        check("b2b_period", 32'(second - first), 32'(WS + 3));
        repeat (WS + 4) @(negedge Clk);
        check("b2b_idle", 32'(Busy), 32'd0);

        // Req pulsed during MEM is ignored
        Req = 1'b1; Rd_Wr = 1'b1; A = 20'h00010; Mem_Din = 16'hBEEF;
        @(negedge Clk);
        Rd_Wr = 1'b0; A = 20'h0FFFF; Data_from_CPU = 16'h1111;
        @(negedge Clk);
        Req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Ready) pulses++;
        end
        check("ignored_pulses", 32'(pulses), 32'd1);
        check("ignored_hex", 32'(HEX_Out), 32'hCAFE);
        check("ignored_data", 32'(Data_to_CPU), 32'hBEEF);
        check("ignored_busy", 32'(Busy), 32'd0);

`ifdef MEM_IO_ACCESS_CNT_EN
        run_vec('{1'b0, 20'h0FFFE, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'hCAFE});
        run_vec('{1'b1, 20'h00010, 16'h0000, 16'h0000, 16'h1357, 16'h1357, 16'hCAFE});
        run_vec('{1'b0, 20'h00030, 16'h2468, 16'h0000, 16'h0000, 16'h1357, 16'hCAFE});
        run_vec('{1'b1, 20'h0FFFF, 16'h0000, 16'h0042, 16'h0000, 16'h0042, 16'hCAFE});
        run_vec('{1'b1, 20'h0FFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'hCAFE});
        run_vec('{1'b0, 20'h0FFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'hCAFE});
        run_vec('{1'b1, 20'h0FFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
